// File: rtl/uartb_tx_burst_pkg.sv
// Shared types and constants for the UARTB burst transmit path:
// transmitter states, config field offsets and async frame constants.
package uartb_tx_burst_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } tx_state_e;

   // Config flag positions, counted upward from bit DIVW of the write word
   localparam int CFG_BURST_OFS  = 0;
   localparam int CFG_PAREN_OFS  = 1;
   localparam int CFG_PARODD_OFS = 2;

   localparam logic START_LVL = 1'b0;
   localparam logic STOP_LVL  = 1'b1;
   localparam logic IDLE_LVL  = 1'b1;
   localparam int   DATA_BITS = 8;

   function automatic logic frame_parity(input logic [7:0] b, input logic odd);
      return (^b) ^ odd;
   endfunction

endpackage

// File: rtl/uartb_tx_burst_fifo.sv
// Byte FIFO with a multi-byte push port (0..NB bytes per cycle) and a
// single-byte pop; push and pop in one cycle are both honoured.
module uartb_tx_burst_fifo #(
   parameter int DEPTH = 8,
   parameter int NB    = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [$clog2(NB+1)-1:0]    push_cnt,
   input  logic [NB*8-1:0]            push_data,
   input  logic                       pop,
   output logic [7:0]                 head,
   output logic [$clog2(DEPTH):0]     level,
   output logic                       empty
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   logic [7:0]    mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;

   // Storage carries no reset; only pointers and occupancy define content
   always_ff @(posedge clk) begin
      for (int i = 0; i < NB; i++) begin
         if (i < int'(push_cnt))
            mem[wr_ptr + AW'(i)] <= push_data[8*i +: 8];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         wr_ptr <= wr_ptr + AW'(push_cnt);
         if (pop)
            rd_ptr <= rd_ptr + AW'(1);
         level <= level + LW'(push_cnt) - LW'(pop);
      end
   end

   assign head  = mem[rd_ptr];
   assign empty = (level == '0);

endmodule

// File: rtl/uartb_tx_burst.sv
// UARTB transmit path: config register, all-or-nothing write acceptance into
// a byte FIFO, and a baud/bit-counted frame serialiser driving txd.
module uartb_tx_burst
   import uartb_tx_burst_pkg::*;
#(
   parameter int DW         = 32,
   parameter int DIVW       = 9,
   parameter int FIFO_DEPTH = 8
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [DW-1:0]                 d,
   input  logic                          wrtx,
   input  logic                          wrbaud,
   output logic                          txd,
   output logic                          thre,
   output logic                          tend,
   output logic [$clog2(FIFO_DEPTH):0]   level,
   output logic                          ovf,
   output tx_state_e                     fsm_state
);

   localparam int NB = DW / 8;
   localparam int LW = $clog2(FIFO_DEPTH) + 1;
   localparam int CW = $clog2(NB + 1);

   // Write side: wrtx is a one-cycle strobe with no back-pressure. thre says
   // a wrtx issued now will be taken; a wrtx without room is dropped whole and
   // latches ovf. There is no pop-side handshake beyond the FIFO itself.
   logic [DIVW-1:0] div_q;
   logic            burst_q;
   logic            paren_q;
   logic            parodd_q;

   logic [LW-1:0]   need;
   logic [LW-1:0]   free;
   logic            room;
   logic [CW-1:0]   push_cnt;
   logic            pop;
   logic [7:0]      head;
   logic            empty;

   assign need     = burst_q ? LW'(NB) : LW'(1);
   assign free     = LW'(FIFO_DEPTH) - level;
   assign room     = (free >= need);
   assign push_cnt = (wrtx && room) ? (burst_q ? CW'(NB) : CW'(1)) : '0;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         div_q    <= '0;
         burst_q  <= 1'b0;
         paren_q  <= 1'b0;
         parodd_q <= 1'b0;
      end else if (wrbaud) begin
         div_q    <= d[DIVW-1:0];
         burst_q  <= d[DIVW + CFG_BURST_OFS];
         paren_q  <= d[DIVW + CFG_PAREN_OFS];
         parodd_q <= d[DIVW + CFG_PARODD_OFS];
      end
   end

   // A drop in the same cycle as a config write still leaves ovf set
   always_ff @(posedge clk) begin
      if (!rst_n)
         ovf <= 1'b0;
      else if (wrtx && !room)
         ovf <= 1'b1;
      else if (wrbaud)
         ovf <= 1'b0;
   end

   uartb_tx_burst_fifo #(
      .DEPTH (FIFO_DEPTH),
      .NB    (NB)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push_cnt  (push_cnt),
      .push_data (d[NB*8-1:0]),
      .pop       (pop),
      .head      (head),
      .level     (level),
      .empty     (empty)
   );

   // Frame registers: timing and parity are frozen at pop time
   tx_state_e       state_q,  state_n;
   logic [DIVW-1:0] baud_q,   baud_n;
   logic [2:0]      bit_q,    bit_n;
   logic [7:0]      shreg_q,  shreg_n;
   logic            txd_q,    txd_n;
   logic [DIVW-1:0] fdiv_q,   fdiv_n;
   logic            fparen_q, fparen_n;
   logic            fpar_q,   fpar_n;
   logic            bit_done;
   logic            load;

   assign bit_done = (baud_q == fdiv_q);

   always_comb begin
      state_n  = state_q;
      baud_n   = baud_q;
      bit_n    = bit_q;
      shreg_n  = shreg_q;
      txd_n    = txd_q;
      fdiv_n   = fdiv_q;
      fparen_n = fparen_q;
      fpar_n   = fpar_q;
      pop      = 1'b0;
      load     = 1'b0;

      if (state_q != ST_IDLE)
         baud_n = bit_done ? '0 : baud_q + DIVW'(1);

      case (state_q)
         ST_IDLE: begin
            txd_n = IDLE_LVL;
            if (!empty)
               load = 1'b1;
         end
         ST_START: begin
            if (bit_done) begin
               state_n = ST_DATA;
               bit_n   = '0;
               txd_n   = shreg_q[0];
            end
         end
         ST_DATA: begin
            if (bit_done) begin
               if (bit_q == 3'(DATA_BITS - 1)) begin
                  state_n = fparen_q ? ST_PARITY : ST_STOP;
                  txd_n   = fparen_q ? fpar_q : STOP_LVL;
               end else begin
                  bit_n   = bit_q + 3'd1;
                  shreg_n = shreg_q >> 1;
                  txd_n   = shreg_q[1];
               end
            end
         end
         ST_PARITY: begin
            if (bit_done) begin
               state_n = ST_STOP;
               txd_n   = STOP_LVL;
            end
         end
         ST_STOP: begin
            if (bit_done) begin
               if (!empty) begin
                  load = 1'b1;
               end else begin
                  state_n = ST_IDLE;
                  txd_n   = IDLE_LVL;
               end
            end
         end
         default: begin
            state_n = ST_IDLE;
            txd_n   = IDLE_LVL;
         end
      endcase

      // Start of a new frame, from IDLE or straight out of STOP
      if (load) begin
         pop      = 1'b1;
         state_n  = ST_START;
         baud_n   = '0;
         shreg_n  = head;
         txd_n    = START_LVL;
         fdiv_n   = div_q;
         fparen_n = paren_q;
         fpar_n   = frame_parity(head, parodd_q);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         baud_q   <= '0;
         bit_q    <= '0;
         shreg_q  <= '0;
         txd_q    <= IDLE_LVL;
         fdiv_q   <= '0;
         fparen_q <= 1'b0;
         fpar_q   <= 1'b0;
      end else begin
         state_q  <= state_n;
         baud_q   <= baud_n;
         bit_q    <= bit_n;
         shreg_q  <= shreg_n;
         txd_q    <= txd_n;
         fdiv_q   <= fdiv_n;
         fparen_q <= fparen_n;
         fpar_q   <= fpar_n;
      end
   end

   assign txd       = txd_q;
   assign thre      = room;
   assign tend      = (state_q == ST_IDLE) && empty;
   assign fsm_state = state_q;

endmodule
